dsp_result_collector: RTL and testbench
=======================================

# dsp_result_collector

Downstream companion of the FB42 DSP slice. It mirrors every issued `start`/`mode` pair through its own latency tracker and captures the DSP's `out` bus in the cycle the corresponding result matures. Captured results are tagged with their issue mode and buffered in a small first-word-fall-through FIFO. The FIFO drains through a valid/ready port, so a slow consumer never has to sample the DSP's single-cycle result bus directly.

## Interface
- `N`, 9: DSP operand width; result width is 2N.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `dsp_start`  in  1  copy of the `start` driven into the DSP.
- `dsp_mode`  in  2  copy of the `mode` driven into the DSP.
- `dsp_out`  in  2N  DSP result bus.
- `dsp_cmp`  in  1  DSP `compare_res`; used only when the check feature is compiled in.
- `clear`  in  1  synchronous flush of the tracker, FIFO and sticky flags.
- `res_valid`  out  1  FIFO non-empty.
- `res_ready`  in  1  consumer accepts the head entry.
- `res_data`  out  2N  head result.
- `res_mode`  out  2  issue mode of the head result.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `ovf_err`  out  1  sticky: a matured result was dropped because the FIFO was full.
- `col_err`  out  1  sticky: two results matured in the same cycle.
- `mode_err`  out  1  sticky: `dsp_start` was seen with `dsp_mode`=11.
- `chk_err`  out  1  sticky: tracker disagreed with `dsp_cmp` (check build only).

## Operation
- Latency per mode: 00 → 0 cycles (result is on `dsp_out` in the issue cycle); 01 → 1 cycle; 10 → 3 cycles.
- Tracker: a 3-stage shift register of {valid, mode}, loaded from `dsp_start`/`dsp_mode`.
- Matured result in cycle t: asserted if any of the following holds:
  - start in cycle t with mode 00;
  - start in cycle t−1 with mode 01;
  - start in cycle t−3 with mode 10.
- Mode 11 starts are not tracked and set `mode_err`.
- Capture: on the edge that closes a maturity cycle, push {mode, `dsp_out`} into the FIFO.
- Collision: if more than one source matures in the same cycle, push once, using the oldest issue (mode 10 over 01 over 00), and set `col_err`.
- Push while full:
  - no pop in that cycle: drop the entry and set `ovf_err`;
  - `res_valid`&`res_ready` in the same cycle: the pop frees a slot, the push is accepted, `count` is unchanged.
- Pop: `res_valid`&`res_ready`; the head advances on that edge.
- Pointer arithmetic: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is decided from `count`.
- `clear`:
  - on the next edge, empties the FIFO, zeroes the tracker and clears every sticky flag;
  - overrides any push or pop in the same cycle;
  - starts in the `clear` cycle are discarded.
- Sticky flags clear only on reset or `clear`.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `res_valid`=0, `res_data`=0, `res_mode`=0, `count`=0;
  - all sticky flags 0;
  - tracker empty.
- `rst_n` falling mid-flight discards all in-flight and buffered results immediately.
- The first edge after `rst_n` rises behaves as from an empty state.
- Start to `res_valid` (empty FIFO, no backpressure):
  - mode 00: 1 cycle;
  - mode 01: 2 cycles;
  - mode 10: 4 cycles.
- `res_data`/`res_mode` are registered FIFO head outputs. They change only after a pop or on a push into an empty FIFO.
- Sustained throughput: one result per cycle in and out.

## Configuration
- Macro `DSP_COLLECT_CHECK_EN`.
- Defined: each cycle, `dsp_cmp` is compared with the tracker's matured indication for the current `dsp_mode`; any mismatch sets `chk_err`.
- Undefined: `dsp_cmp` is unused and `chk_err` is tied to 0.

## Test plan
- Mode 10 start at cycle 0 with `dsp_out`=0x00123 at cycle 3 → `res_valid` rises cycle 4, `res_data`=0x00123, `res_mode`=2, `count`=1; pop → `count`=0.
- Back-to-back mode 00 starts on cycles 0..4 with DEPTH=4 and `res_ready`=0 → 4 entries in order, `count`=4, the fifth is dropped and `ovf_err`=1.
- FIFO full with `res_ready`=1 and a mode 01 maturing in the same cycle → the push is accepted, `count` stays 4, `ovf_err` stays 0.
- Mode 10 at cycle 0 and mode 00 at cycle 3 → one entry with `res_mode`=2 and `col_err`=1.
- Start with mode 11 → no entry, `mode_err`=1; then `clear` → all flags 0, `count`=0.
- `rst_n` low while a mode 10 result is in flight → no entry ever appears, all outputs 0; with `DSP_COLLECT_CHECK_EN`, forcing `dsp_cmp` high with no start → `chk_err`=1.

Source files
------------

// File: rtl/dsp_result_collector.sv
// Collects FB42 DSP results into a mode-tagged FWFT FIFO behind a valid/ready port.
// Optional macro DSP_COLLECT_CHECK_EN compares dsp_cmp against the tracker and raises chk_err.
module dsp_result_collector #(
  parameter int N     = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dsp_start,
  input  logic [1:0]                 dsp_mode,
  input  logic [2*N-1:0]             dsp_out,
  input  logic                       dsp_cmp,
  input  logic                       clear,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [2*N-1:0]             res_data,
  output logic [1:0]                 res_mode,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_err,
  output logic                       col_err,
  output logic                       mode_err,
  output logic                       chk_err
);
  localparam int W  = 2 * N;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]      trk_vld_reg;
  logic [1:0]      trk_mode_reg [3];
  logic [W+1:0]    mem [DEPTH];
  logic [W+1:0]    head_reg;
  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            ovf_err_reg, col_err_reg, mode_err_reg;

  logic            m00, m01, m10, push, collide, full, empty, pop, push_acc;
  logic [1:0]      push_mode;
  logic [W+1:0]    push_word;
  logic [CW-1:0]   count_next;
  logic [PW-1:0]   rd_ptr_inc;

  always_comb begin
    m00        = dsp_start && (dsp_mode == 2'b00);
    m01        = trk_vld_reg[0] && (trk_mode_reg[0] == 2'b01);
    m10        = trk_vld_reg[2] && (trk_mode_reg[2] == 2'b10);
    push       = m00 | m01 | m10;
    collide    = (m00 & m01) | (m00 & m10) | (m01 & m10);
    // Oldest issue wins a collision
    push_mode  = m10 ? 2'b10 : (m01 ? 2'b01 : 2'b00);
    push_word  = {push_mode, dsp_out};
    full       = (count_reg == CW'(DEPTH));
    empty      = (count_reg == '0);
    pop        = !empty && res_ready;
    push_acc   = push && (!full || pop);
    rd_ptr_inc = rd_ptr_reg + PW'(1);
    count_next = count_reg;
    if (push_acc && !pop)      count_next = count_reg + CW'(1);
    else if (pop && !push_acc) count_next = count_reg - CW'(1);
  end

  // Tracker: stage k holds the start issued k+1 cycles ago; mode 11 is never tracked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld_reg     <= '0;
      trk_mode_reg[0] <= '0;
    end else if (clear) begin
      trk_vld_reg[0]  <= 1'b0;
      trk_mode_reg[0] <= '0;
    end else begin
      trk_vld_reg[0]  <= dsp_start && (dsp_mode != 2'b11);
      trk_mode_reg[0] <= dsp_mode;
    end
  end

  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_trk
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
          trk_vld_reg[gi]  <= 1'b0;
          trk_mode_reg[gi] <= '0;
        end else begin
          trk_vld_reg[gi]  <= trk_vld_reg[gi-1];
          trk_mode_reg[gi] <= trk_mode_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push_acc && !clear) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      ovf_err_reg  <= 1'b0;
      col_err_reg  <= 1'b0;
      mode_err_reg <= 1'b0;
    end else if (clear) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      ovf_err_reg  <= 1'b0;
      col_err_reg  <= 1'b0;
      mode_err_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)      rd_ptr_reg <= rd_ptr_inc;
      // Head register: refill from the next slot on pop, or bypass the push into an empty FIFO
      if (pop) begin
        if (count_reg > CW'(1)) head_reg <= mem[rd_ptr_inc];
        else if (push_acc)      head_reg <= push_word;
      end else if (push_acc && empty) begin
        head_reg <= push_word;
      end
      if (push && full && !pop)              ovf_err_reg  <= 1'b1;
      if (collide)                           col_err_reg  <= 1'b1;
      if (dsp_start && dsp_mode == 2'b11)    mode_err_reg <= 1'b1;
    end
  end

`ifdef DSP_COLLECT_CHECK_EN
  logic chk_err_reg;
  logic cmp_exp;

  always_comb begin
    cmp_exp = 1'b0;
    case (dsp_mode)
      2'b00:   cmp_exp = dsp_start;
      2'b01:   cmp_exp = m01;
      2'b10:   cmp_exp = m10;
      default: cmp_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   chk_err_reg <= 1'b0;
    else if (clear)               chk_err_reg <= 1'b0;
    else if (dsp_cmp != cmp_exp)  chk_err_reg <= 1'b1;
  end

  assign chk_err = chk_err_reg;
`else
  logic unused_cmp;
  assign unused_cmp = dsp_cmp;
  assign chk_err    = 1'b0;
`endif

  assign res_valid = !empty;
  assign res_data  = head_reg[W-1:0];
  assign res_mode  = head_reg[W+1:W];
  assign count     = count_reg;
  assign ovf_err   = ovf_err_reg;
  assign col_err   = col_err_reg;
  assign mode_err  = mode_err_reg;
endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench for dsp_result_collector: latency, ordering, overflow, collision, clear, reset.
module tb_dsp_result_collector;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dsp_start;
  logic [1:0]  dsp_mode;
  logic [17:0] dsp_out;
  logic        dsp_cmp;
  logic        clear;
  logic        res_valid;
  logic        res_ready;
  logic [17:0] res_data;
  logic [1:0]  res_mode;
  logic [2:0]  count;
  logic        ovf_err, col_err, mode_err, chk_err;

  int vectors = 0;
  int miscompares = 0;

  dsp_result_collector #(.N(9), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .dsp_start(dsp_start), .dsp_mode(dsp_mode),
    .dsp_out(dsp_out), .dsp_cmp(dsp_cmp), .clear(clear), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_mode(res_mode), .count(count),
    .ovf_err(ovf_err), .col_err(col_err), .mode_err(mode_err), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
    $display("vec %0d %s got=%0h exp=%0h", vectors, tag, got, exp);
  endtask

  task automatic idle();
    dsp_start = 1'b0; dsp_mode = 2'b00; res_ready = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dsp_out = '0; dsp_cmp = 1'b0;
    idle();
    tick();
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {ovf_err, col_err, mode_err, chk_err}, 0);
    rst_n = 1'b1;
    tick();

    // Mode 10 latency
    dsp_start = 1'b1; dsp_mode = 2'b10; tick();
    dsp_start = 1'b0; tick();
    tick();
    chk("m10_not_yet", 32'(res_valid), 0);
    dsp_out = 18'h00123; tick();
    chk("m10_valid", 32'(res_valid), 1);
    chk("m10_data", 32'(res_data), 32'h123);
    chk("m10_mode", 32'(res_mode), 2);
    chk("m10_count", 32'(count), 1);
    res_ready = 1'b1; tick();
    res_ready = 1'b0;
    chk("m10_pop_count", 32'(count), 0);
    chk("m10_pop_valid", 32'(res_valid), 0);

    // Five back-to-back mode 00 starts into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      dsp_start = 1'b1; dsp_mode = 2'b00; dsp_out = 18'(32'h10 + i);
      tick();
      if (i == 3) chk("fill_ovf_before", 32'(ovf_err), 0);
    end
    dsp_start = 1'b0;
    chk("fill_count", 32'(count), 4);
    chk("fill_ovf", 32'(ovf_err), 1);
    chk("fill_head", 32'(res_data), 32'h10);
    chk("fill_head_mode", 32'(res_mode), 0);

    // Clear, refill, then push-with-pop while full
    do_clear();
    chk("clr_count", 32'(count), 0);
    chk("clr_ovf", 32'(ovf_err), 0);
    for (int i = 0; i < 4; i++) begin
      dsp_start = 1'b1; dsp_mode = 2'b00; dsp_out = 18'(32'h20 + i);
      tick();
    end
    dsp_start = 1'b1; dsp_mode = 2'b01; dsp_out = 18'h3ff; tick();
    chk("full_count", 32'(count), 4);
    dsp_start = 1'b0; dsp_mode = 2'b00; dsp_out = 18'h55; res_ready = 1'b1; tick();
    chk("pp_count", 32'(count), 4);
    chk("pp_ovf", 32'(ovf_err), 0);
    chk("pp_head", 32'(res_data), 32'h21);
    tick(); chk("drain_22", 32'(res_data), 32'h22);
    tick(); chk("drain_23", 32'(res_data), 32'h23);
    tick(); chk("drain_55", 32'(res_data), 32'h55);
    chk("drain_55_mode", 32'(res_mode), 1);
    chk("drain_55_count", 32'(count), 1);
    tick(); chk("drain_empty", 32'(count), 0);
    res_ready = 1'b0;

    // Collision: mode 10 at cycle 0 and mode 00 at cycle 3
    do_clear();
    dsp_start = 1'b1; dsp_mode = 2'b10; tick();
    dsp_start = 1'b0; tick();
    tick();
    dsp_start = 1'b1; dsp_mode = 2'b00; dsp_out = 18'h77; tick();
    dsp_start = 1'b0;
    chk("col_count", 32'(count), 1);
    chk("col_mode", 32'(res_mode), 2);
    chk("col_data", 32'(res_data), 32'h77);
    chk("col_err", 32'(col_err), 1);
    tick(); tick(); tick();
    chk("col_count_later", 32'(count), 1);

    // Mode 11 start, then clear
    do_clear();
    chk("clr_col", 32'(col_err), 0);
    dsp_start = 1'b1; dsp_mode = 2'b11; tick();
    dsp_start = 1'b0; dsp_mode = 2'b00;
    chk("m11_mode_err", 32'(mode_err), 1);
    tick(); tick(); tick();
    chk("m11_count", 32'(count), 0);
    do_clear();
    chk("m11_clr_flags", {ovf_err, col_err, mode_err, chk_err}, 0);
    chk("m11_clr_count", 32'(count), 0);

    // Asynchronous reset with a mode 10 result in flight
    dsp_start = 1'b1; dsp_mode = 2'b10; tick();
    dsp_start = 1'b0; tick();
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {res_valid, res_data, res_mode, count, ovf_err, col_err, mode_err, chk_err}, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arst_no_entry", 32'(res_valid), 0);
    end
    chk("arst_count", 32'(count), 0);
    dsp_cmp = 1'b1; tick();
    dsp_cmp = 1'b0;
`ifdef DSP_COLLECT_CHECK_EN
    chk("chk_err_set", 32'(chk_err), 1);
`else
    chk("chk_err_tied", 32'(chk_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
